// File: rtl/led_driver_rx_if.sv
// ----------------------------------------------------------------------------
// led_driver_rx_if
// Serial LED-driver link as seen by one receiver (a chain of driver chips).
//
// Parameters:
//   W          frame length in bits (WIDTH*CHAIN of the receiver)
//   ERR_CNT_W  width of the saturating frame-error counter
//
// Signals (master = link driver / bench, slave = receiver):
//   shift, serial_data_in           serial bit strobe and data, MSB first
//   latch_led_vals, latch_brightness capture strobes for the two frame targets
//   clear_error                     clears the sticky error flag and counter
//   led_vals, brightness            last good frame of each kind
//   led_vals_valid, brightness_valid one-cycle update pulses
//   serial_data_out                 cascade output (MSB of shift register)
//   state                           0 IDLE, 1 SHIFTING, 2 FULL, 3 OVERRUN
//   frame_error, error_count        sticky length error and bad-latch count
// ----------------------------------------------------------------------------
interface led_driver_rx_if #(
    parameter int W         = 16,
    parameter int ERR_CNT_W = 8
);
    logic                 shift;
    logic                 serial_data_in;
    logic                 latch_led_vals;
    logic                 latch_brightness;
    logic                 clear_error;
    logic [W-1:0]         led_vals;
    logic [W-1:0]         brightness;
    logic                 led_vals_valid;
    logic                 brightness_valid;
    logic                 serial_data_out;
    logic [1:0]           state;
    logic                 frame_error;
    logic [ERR_CNT_W-1:0] error_count;

    modport master (
        output shift, serial_data_in, latch_led_vals, latch_brightness, clear_error,
        input  led_vals, brightness, led_vals_valid, brightness_valid,
               serial_data_out, state, frame_error, error_count
    );

    modport slave (
        input  shift, serial_data_in, latch_led_vals, latch_brightness, clear_error,
        output led_vals, brightness, led_vals_valid, brightness_valid,
               serial_data_out, state, frame_error, error_count
    );
endinterface

// File: rtl/led_driver_rx.sv
// ----------------------------------------------------------------------------
// led_driver_rx
// Serial-in/parallel-out model of a (possibly cascaded) LED driver chip.
// Bits are shifted in MSB first on 'shift'; a latch strobe captures the whole
// frame into led_vals or brightness if exactly W bits were received since the
// previous latch, otherwise the frame is rejected and an error is recorded.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    led_driver_rx_if.slave (see interface header for signal list)
// ----------------------------------------------------------------------------
module led_driver_rx #(
    parameter int WIDTH     = 16,
    parameter int CHAIN     = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    led_driver_rx_if.slave   bus
);

    localparam int W  = WIDTH * CHAIN;
    // Count runs 0..W+1, so it must hold W+1.
    localparam int CW = $clog2(W + 2);

    localparam logic [CW-1:0]        CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]        CNT_FULL = CW'(W);
    localparam logic [CW-1:0]        CNT_OVER = CW'(W + 1);
    localparam logic [ERR_CNT_W-1:0] ERR_ZERO = {ERR_CNT_W{1'b0}};
    localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFTING = 2'd1,
        ST_FULL     = 2'd2,
        ST_OVERRUN  = 2'd3
    } state_t;

    logic [W-1:0]         sr_r,          sr_s;
    logic [CW-1:0]        cnt_r,         cnt_s;
    logic [CW-1:0]        cnt_eff_s;
    state_t               state_r,       state_s;
    logic [W-1:0]         led_vals_r,    led_vals_s;
    logic [W-1:0]         brightness_r,  brightness_s;
    logic                 led_valid_r,   led_valid_s;
    logic                 bri_valid_r,   bri_valid_s;
    logic                 frame_error_r, frame_error_s;
    logic [ERR_CNT_W-1:0] err_cnt_r,     err_cnt_s;
    logic                 any_latch_s;
    logic                 good_latch_s;
    logic                 bad_latch_s;

    // Next-state logic: latches are judged on the post-shift data and count.
    always_comb begin
        sr_s          = sr_r;
        cnt_eff_s     = cnt_r;
        cnt_s         = cnt_r;
        state_s       = state_r;
        led_vals_s    = led_vals_r;
        brightness_s  = brightness_r;
        led_valid_s   = 1'b0;
        bri_valid_s   = 1'b0;
        frame_error_s = frame_error_r;
        err_cnt_s     = err_cnt_r;

        if (bus.shift) begin
            sr_s = {sr_r[W-2:0], bus.serial_data_in};
        end else begin
            sr_s = sr_r;
        end

        // Count saturates one past full so overrun stays visible.
        if (bus.shift && (cnt_r != CNT_OVER)) begin
            cnt_eff_s = cnt_r + CNT_ONE;
        end else begin
            cnt_eff_s = cnt_r;
        end

        any_latch_s  = bus.latch_led_vals | bus.latch_brightness;
        good_latch_s = any_latch_s && (cnt_eff_s == CNT_FULL);
        bad_latch_s  = any_latch_s && (cnt_eff_s != CNT_FULL);

        // Any latch restarts framing; the shift register is kept for cascade.
        if (any_latch_s) begin
            cnt_s = CNT_ZERO;
        end else begin
            cnt_s = cnt_eff_s;
        end

        if (good_latch_s && bus.latch_led_vals) begin
            led_vals_s  = sr_s;
            led_valid_s = 1'b1;
        end else begin
            led_vals_s  = led_vals_r;
            led_valid_s = 1'b0;
        end

        if (good_latch_s && bus.latch_brightness) begin
            brightness_s = sr_s;
            bri_valid_s  = 1'b1;
        end else begin
            brightness_s = brightness_r;
            bri_valid_s  = 1'b0;
        end

        // A bad latch beats a simultaneous clear: the clear happens first.
        if (bad_latch_s) begin
            frame_error_s = 1'b1;
            if (bus.clear_error) begin
                err_cnt_s = ERR_ONE;
            end else if (err_cnt_r != ERR_MAX) begin
                err_cnt_s = err_cnt_r + ERR_ONE;
            end else begin
                err_cnt_s = err_cnt_r;
            end
        end else if (bus.clear_error) begin
            frame_error_s = 1'b0;
            err_cnt_s     = ERR_ZERO;
        end else begin
            frame_error_s = frame_error_r;
            err_cnt_s     = err_cnt_r;
        end

        // State is a pure function of the next bit count.
        case (cnt_s)
            CNT_ZERO: state_s = ST_IDLE;
            CNT_FULL: state_s = ST_FULL;
            CNT_OVER: state_s = ST_OVERRUN;
            default:  state_s = ST_SHIFTING;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_r          <= {W{1'b0}};
            cnt_r         <= CNT_ZERO;
            state_r       <= ST_IDLE;
            led_vals_r    <= {W{1'b0}};
            brightness_r  <= {W{1'b0}};
            led_valid_r   <= 1'b0;
            bri_valid_r   <= 1'b0;
            frame_error_r <= 1'b0;
            err_cnt_r     <= ERR_ZERO;
        end else begin
            sr_r          <= sr_s;
            cnt_r         <= cnt_s;
            state_r       <= state_s;
            led_vals_r    <= led_vals_s;
            brightness_r  <= brightness_s;
            led_valid_r   <= led_valid_s;
            bri_valid_r   <= bri_valid_s;
            frame_error_r <= frame_error_s;
            err_cnt_r     <= err_cnt_s;
        end
    end

    assign bus.led_vals         = led_vals_r;
    assign bus.brightness       = brightness_r;
    assign bus.led_vals_valid   = led_valid_r;
    assign bus.brightness_valid = bri_valid_r;
    // Straight from the register so the next chip sees the previous frame.
    assign bus.serial_data_out  = sr_r[W-1];
    assign bus.state            = state_r;
    assign bus.frame_error      = frame_error_r;
    assign bus.error_count      = err_cnt_r;

endmodule
